prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Byte-stream program loader that writes a memory image into one write port of the core's dual-port instruction/data RAM.
- Holds the core in reset until the image has been written and its checksum verified.
- Sits between a UART/debug byte source and RAM port B. The core keeps port A.
- The loader is the RAM's writer; the core-side fetch is the reader.

Parameters:
ADDR_WIDTH, 22, width of the RAM byte address bus (matches the RAM's ADDR_WIDTH).
CNT_WIDTH, 32, width of the word-count field and counter.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
restart_i  in  1  synchronous pulse; abort and restart framing
byte_valid_i  in  1  input byte valid
byte_i  in  8  input byte
byte_ready_o  out  1  loader accepts byte_i this cycle
ram_en_o  out  1  RAM port enable (write strobe cycle)
ram_we_o  out  1  RAM write enable
ram_be_o  out  4  byte enables, always 4'hF when writing
ram_addr_o  out  ADDR_WIDTH  word-aligned byte address
ram_wdata_o  out  32  write data
core_rst_no  out  1  core reset, active low
loaded_o  out  1  image loaded and verified
err_o  out  1  checksum mismatch
words_o  out  CNT_WIDTH  words written so far

Behaviour:
- Byte transfer occurs when byte_valid_i && byte_ready_o at a rising edge.
- Frame format, all multi-byte fields little-endian:
  - 4 bytes: base address.
  - 4 bytes: word count N.
  - 4*N bytes: data words, little-endian per word.
  - 1 byte: checksum = XOR of all preceding frame bytes.
- FSM states: S_ADDR, S_LEN, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR.
- Reset (async, rst_ni low) → S_ADDR. All outputs 0, including core_rst_no=0. Byte counter, word counter, address register, shift register and running XOR are cleared.
- S_ADDR: byte_ready_o=1. After 4 bytes → S_LEN.
  - Stored address = {addr[ADDR_WIDTH-1:2], 2'b00}. Upper bits beyond ADDR_WIDTH and bits [1:0] are discarded.
- S_LEN: byte_ready_o=1. After 4 bytes → S_CSUM if N==0, else S_DATA.
- S_DATA: byte_ready_o=1. Bytes are assembled LSB-first. On the 4th byte → S_WRITE.
- S_WRITE: exactly one cycle.
  - byte_ready_o=0.
  - ram_en_o=ram_we_o=1, ram_be_o=4'hF.
  - ram_addr_o = current address, ram_wdata_o = assembled word.
  - Next cycle: address += 4, wrapping modulo 2^ADDR_WIDTH; words_o += 1.
  - Then → S_CSUM if words_o+1==N, else S_DATA.
- Outside S_WRITE: ram_en_o=ram_we_o=0, ram_be_o=0. ram_addr_o and ram_wdata_o hold their last values.
- The running XOR includes every accepted byte in S_ADDR, S_LEN and S_DATA.
- S_CSUM: byte_ready_o=1. On accept:
  - byte == XOR → S_DONE.
  - otherwise → S_ERR.
- S_DONE: loaded_o=1, core_rst_no=1, byte_ready_o=0. Registered, so both rise one cycle after the checksum byte is accepted.
- S_ERR: err_o=1, core_rst_no=0, byte_ready_o=0.
- restart_i in any state → S_ADDR next cycle.
  - Clears counters, XOR, loaded_o, err_o and words_o.
  - Drives core_rst_no=0.
  - Has priority over a simultaneous byte transfer; that byte is dropped.
  - A write in progress in S_WRITE still completes in that cycle; restart only affects the next state.
- Stalls: byte_valid_i low in any receiving state holds state and all counters.
- Word count wrap: the counter compares against the full CNT_WIDTH N. No early termination.
- Address wrap past 2^ADDR_WIDTH-4 continues at 0. No error is raised.
- rst_ni asserted mid-frame immediately returns all outputs to reset values. No partial write is issued after reset assertion.

Test Plan:
- Frame: addr 0x00000100, N=2, data 0xDEADBEEF, 0x00000013, correct checksum → exactly two writes, at 0x100 (0xDEADBEEF) and 0x104 (0x00000013), be=4'hF; words_o=2; loaded_o=1 and core_rst_no=1 one cycle after the checksum byte; err_o=0.
- Same frame with the checksum byte XOR 0x01 → both writes still occur; S_ERR: err_o=1, core_rst_no=0, loaded_o=0; then restart_i pulse → err_o=0 and the loader accepts a new frame.
- N=0 with addr 0x00000003 → no RAM write; checksum accepted → loaded_o=1, words_o=0.
- Base 0x3FFFFC (ADDR_WIDTH=22), N=2 → writes at 0x3FFFFC, then 0x000000.
- Random byte_valid_i gaps (50% duty) on the first frame → RAM writes identical to the gap-free run; byte_ready_o=0 in every write cycle.
- restart_i asserted during the 3rd data byte, and separately rst_ni pulsed low mid-frame → no further writes; a fresh frame loads correctly; core_rst_no stays 0 until the new checksum passes.

Source files
------------

// File: rtl/prog_loader.sv
// Byte-stream program loader: frames {addr, count, data words, xor checksum} into RAM port B writes.
// Latency: one write strobe cycle after each 4th data byte; loaded/core reset release one cycle after checksum byte.
// Backpressure: byte_ready_o drops in the write cycle and after the checksum; a low byte_valid_i simply stalls.
`timescale 1ns/1ps

module prog_loader #(
   parameter int ADDR_WIDTH = 22,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  restart_i,
   input  logic                  byte_valid_i,
   input  logic [7:0]            byte_i,
   output logic                  byte_ready_o,
   output logic                  ram_en_o,
   output logic                  ram_we_o,
   output logic [3:0]            ram_be_o,
   output logic [ADDR_WIDTH-1:0] ram_addr_o,
   output logic [31:0]           ram_wdata_o,
   output logic                  core_rst_no,
   output logic                  loaded_o,
   output logic                  err_o,
   output logic [CNT_WIDTH-1:0]  words_o
);

   typedef enum logic [2:0] {
      S_ADDR, S_LEN, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
   } state_e;

   state_e                state_q;
   logic [1:0]            byte_cnt_q;
   logic [31:0]           shift_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [CNT_WIDTH-1:0]  len_q;
   logic [CNT_WIDTH-1:0]  words_q;
   logic [7:0]            xor_q;
   logic                  ready_q;
   logic                  ram_en_q;
   logic [ADDR_WIDTH-1:0] ram_addr_q;
   logic [31:0]           ram_wdata_q;
   logic                  loaded_q;
   logic                  err_q;
   logic                  core_rst_n_q;

   // Byte handshake, little-endian word assembly and running checksum next values
   logic                  xfer_d;
   logic [31:0]           word_d;
   logic [7:0]            xor_d;
   logic [CNT_WIDTH-1:0]  words_inc_d;
   logic [CNT_WIDTH-1:0]  len_field_d;

   assign xfer_d      = byte_valid_i & ready_q;
   assign word_d      = {byte_i, shift_q[31:8]};
   assign xor_d       = xor_q ^ byte_i;
   assign words_inc_d = words_q + CNT_WIDTH'(1);
   assign len_field_d = CNT_WIDTH'(word_d);

   // Framing FSM with all outputs registered; restart overrides any byte accepted in the same cycle
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= S_ADDR;
         byte_cnt_q   <= 2'd0;
         shift_q      <= 32'd0;
         addr_q       <= '0;
         len_q        <= '0;
         words_q      <= '0;
         xor_q        <= 8'd0;
         ready_q      <= 1'b0;
         ram_en_q     <= 1'b0;
         ram_addr_q   <= '0;
         ram_wdata_q  <= 32'd0;
         loaded_q     <= 1'b0;
         err_q        <= 1'b0;
         core_rst_n_q <= 1'b0;
      end else begin
         ram_en_q <= 1'b0;
         if (restart_i) begin
            state_q      <= S_ADDR;
            byte_cnt_q   <= 2'd0;
            shift_q      <= 32'd0;
            len_q        <= '0;
            words_q      <= '0;
            xor_q        <= 8'd0;
            ready_q      <= 1'b1;
            loaded_q     <= 1'b0;
            err_q        <= 1'b0;
            core_rst_n_q <= 1'b0;
         end else begin
            case (state_q)
               S_ADDR: begin
                  ready_q <= 1'b1;
                  if (xfer_d) begin
                     byte_cnt_q <= byte_cnt_q + 2'd1;
                     shift_q    <= word_d;
                     xor_q      <= xor_d;
                     if (byte_cnt_q == 2'd3) begin
                        addr_q  <= {word_d[ADDR_WIDTH-1:2], 2'b00};
                        state_q <= S_LEN;
                     end
                  end
               end
               S_LEN: begin
                  ready_q <= 1'b1;
                  if (xfer_d) begin
                     byte_cnt_q <= byte_cnt_q + 2'd1;
                     shift_q    <= word_d;
                     xor_q      <= xor_d;
                     if (byte_cnt_q == 2'd3) begin
                        len_q   <= len_field_d;
                        state_q <= (len_field_d == '0) ? S_CSUM : S_DATA;
                     end
                  end
               end
               S_DATA: begin
                  ready_q <= 1'b1;
                  if (xfer_d) begin
                     byte_cnt_q <= byte_cnt_q + 2'd1;
                     shift_q    <= word_d;
                     xor_q      <= xor_d;
                     if (byte_cnt_q == 2'd3) begin
                        ram_en_q    <= 1'b1;
                        ram_addr_q  <= addr_q;
                        ram_wdata_q <= word_d;
                        ready_q     <= 1'b0;
                        state_q     <= S_WRITE;
                     end
                  end
               end
               S_WRITE: begin
                  ready_q <= 1'b1;
                  addr_q  <= addr_q + ADDR_WIDTH'(4);
                  words_q <= words_inc_d;
                  state_q <= (words_inc_d == len_q) ? S_CSUM : S_DATA;
               end
               S_CSUM: begin
                  ready_q <= 1'b1;
                  if (xfer_d) begin
                     ready_q <= 1'b0;
                     if (byte_i == xor_q) begin
                        loaded_q     <= 1'b1;
                        core_rst_n_q <= 1'b1;
                        state_q      <= S_DONE;
                     end else begin
                        err_q   <= 1'b1;
                        state_q <= S_ERR;
                     end
                  end
               end
               S_DONE: ready_q <= 1'b0;
               S_ERR:  ready_q <= 1'b0;
               default: begin
                  ready_q <= 1'b0;
                  state_q <= S_ADDR;
               end
            endcase
         end
      end
   end

   assign byte_ready_o = ready_q;
   assign ram_en_o     = ram_en_q;
   assign ram_we_o     = ram_en_q;
   assign ram_be_o     = {4{ram_en_q}};
   assign ram_addr_o   = ram_addr_q;
   assign ram_wdata_o  = ram_wdata_q;
   assign core_rst_no  = core_rst_n_q;
   assign loaded_o     = loaded_q;
   assign err_o        = err_q;
   assign words_o      = words_q;

endmodule

// File: tb/tb_prog_loader.sv
`timescale 1ns/1ps

module tb_prog_loader;
   localparam int AW = 22;
   localparam int CW = 32;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          restart_i = 1'b0;
   logic          byte_valid_i = 1'b0;
   logic [7:0]    byte_i = 8'd0;
   logic          byte_ready_o;
   logic          ram_en_o;
   logic          ram_we_o;
   logic [3:0]    ram_be_o;
   logic [AW-1:0] ram_addr_o;
   logic [31:0]   ram_wdata_o;
   logic          core_rst_no;
   logic          loaded_o;
   logic          err_o;
   logic [CW-1:0] words_o;

   int checks = 0;
   int failures = 0;
   bit gaps = 1'b0;
   logic [31:0] dw [4];

   logic [31:0] wr_addr [$];
   logic [31:0] wr_data [$];
   logic [3:0]  wr_be   [$];
   logic        wr_we   [$];
   logic        wr_rdy  [$];

   prog_loader #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .restart_i    (restart_i),
      .byte_valid_i (byte_valid_i),
      .byte_i       (byte_i),
      .byte_ready_o (byte_ready_o),
      .ram_en_o     (ram_en_o),
      .ram_we_o     (ram_we_o),
      .ram_be_o     (ram_be_o),
      .ram_addr_o   (ram_addr_o),
      .ram_wdata_o  (ram_wdata_o),
      .core_rst_no  (core_rst_no),
      .loaded_o     (loaded_o),
      .err_o        (err_o),
      .words_o      (words_o)
   );

   always #5 clk_i = ~clk_i;

   // Write-cycle log, sampled mid-cycle
   always @(negedge clk_i) begin
      if (ram_en_o) begin
         wr_addr.push_back(32'(ram_addr_o));
         wr_data.push_back(ram_wdata_o);
         wr_be.push_back(ram_be_o);
         wr_we.push_back(ram_we_o);
         wr_rdy.push_back(byte_ready_o);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      if (gaps) begin
         while ($urandom_range(0, 1) == 1) begin
            byte_valid_i = 1'b0;
            @(negedge clk_i);
         end
      end
      byte_valid_i = 1'b1;
      byte_i = b;
      while (!byte_ready_o && n < 200) begin
         @(negedge clk_i);
         n++;
      end
      chk("byte_ready_timeout", 32'(n < 200), 32'd1);
      @(negedge clk_i);
      byte_valid_i = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, inout logic [7:0] x);
      for (int i = 0; i < 4; i++) begin
         send_byte(w[8*i +: 8]);
         x = x ^ w[8*i +: 8];
      end
   endtask

   task automatic send_frame(input logic [31:0] addr, input logic [31:0] n, input logic [7:0] flip);
      logic [7:0] x = 8'd0;
      send_word(addr, x);
      send_word(n, x);
      for (int w = 0; w < int'(n); w++) send_word(dw[w], x);
      chk("pre_csum_loaded", 32'(loaded_o), 32'd0);
      chk("pre_csum_core_rst_n", 32'(core_rst_no), 32'd0);
      send_byte(x ^ flip);
   endtask

   task automatic pulse_restart();
      restart_i = 1'b1;
      @(negedge clk_i);
      restart_i = 1'b0;
   endtask

   task automatic clear_log();
      wr_addr.delete(); wr_data.delete(); wr_be.delete(); wr_we.delete(); wr_rdy.delete();
   endtask

   task automatic check_writes(input string tag, input int n,
                               input logic [31:0] a0, input logic [31:0] d0,
                               input logic [31:0] a1, input logic [31:0] d1);
      logic [31:0] ea [2];
      logic [31:0] ed [2];
      ea[0] = a0; ea[1] = a1; ed[0] = d0; ed[1] = d1;
      chk({tag, "_wr_count"}, 32'(wr_addr.size()), 32'(n));
      for (int i = 0; i < n && i < wr_addr.size(); i++) begin
         chk({tag, "_wr_addr"}, wr_addr[i], ea[i]);
         chk({tag, "_wr_data"}, wr_data[i], ed[i]);
         chk({tag, "_wr_be"}, 32'(wr_be[i]), 32'hF);
         chk({tag, "_wr_we"}, 32'(wr_we[i]), 32'd1);
         chk({tag, "_wr_rdy_low"}, 32'(wr_rdy[i]), 32'd0);
      end
      clear_log();
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk_i);
      chk("rst_core_rst_n", 32'(core_rst_no), 32'd0);
      chk("rst_loaded", 32'(loaded_o), 32'd0);
      chk("rst_err", 32'(err_o), 32'd0);
      chk("rst_ready", 32'(byte_ready_o), 32'd0);
      chk("rst_ram_en", 32'(ram_en_o), 32'd0);
      chk("rst_words", words_o, 32'd0);
      rst_ni = 1'b1;
      @(negedge clk_i);

      // Basic frame: two words at 0x100
      dw[0] = 32'hDEADBEEF; dw[1] = 32'h00000013;
      send_frame(32'h00000100, 32'd2, 8'h00);
      chk("t1_loaded", 32'(loaded_o), 32'd1);
      chk("t1_core_rst_n", 32'(core_rst_no), 32'd1);
      chk("t1_err", 32'(err_o), 32'd0);
      chk("t1_words", words_o, 32'd2);
      chk("t1_ready_done", 32'(byte_ready_o), 32'd0);
      check_writes("t1", 2, 32'h100, 32'hDEADBEEF, 32'h104, 32'h00000013);

      // Corrupted checksum, then restart
      pulse_restart();
      send_frame(32'h00000100, 32'd2, 8'h01);
      chk("t2_err", 32'(err_o), 32'd1);
      chk("t2_loaded", 32'(loaded_o), 32'd0);
      chk("t2_core_rst_n", 32'(core_rst_no), 32'd0);
      check_writes("t2", 2, 32'h100, 32'hDEADBEEF, 32'h104, 32'h00000013);
      pulse_restart();
      chk("t2_err_cleared", 32'(err_o), 32'd0);
      chk("t2_words_cleared", words_o, 32'd0);
      chk("t2_ready_after_restart", 32'(byte_ready_o), 32'd1);

      // Empty image with unaligned base
      send_frame(32'h00000003, 32'd0, 8'h00);
      chk("t3_loaded", 32'(loaded_o), 32'd1);
      chk("t3_core_rst_n", 32'(core_rst_no), 32'd1);
      chk("t3_words", words_o, 32'd0);
      check_writes("t3", 0, 32'h0, 32'h0, 32'h0, 32'h0);

      // Address wrap at top of RAM
      pulse_restart();
      dw[0] = 32'h11223344; dw[1] = 32'hA5A55A5A;
      send_frame(32'h003FFFFC, 32'd2, 8'h00);
      chk("t4_loaded", 32'(loaded_o), 32'd1);
      chk("t4_words", words_o, 32'd2);
      check_writes("t4", 2, 32'h3FFFFC, 32'h11223344, 32'h000000, 32'hA5A55A5A);

      // Basic frame with random valid gaps
      pulse_restart();
      dw[0] = 32'hDEADBEEF; dw[1] = 32'h00000013;
      gaps = 1'b1;
      send_frame(32'h00000100, 32'd2, 8'h00);
      gaps = 1'b0;
      chk("t5_loaded", 32'(loaded_o), 32'd1);
      chk("t5_words", words_o, 32'd2);
      check_writes("t5", 2, 32'h100, 32'hDEADBEEF, 32'h104, 32'h00000013);

      // Restart during third data byte, then a fresh frame
      pulse_restart();
      begin
         logic [7:0] x = 8'd0;
         send_word(32'h00000200, x);
         send_word(32'd2, x);
         send_byte(8'h01);
         send_byte(8'h02);
      end
      byte_valid_i = 1'b1; byte_i = 8'h03; restart_i = 1'b1;
      @(negedge clk_i);
      byte_valid_i = 1'b0; restart_i = 1'b0;
      repeat (6) @(negedge clk_i);
      chk("t6_core_rst_n", 32'(core_rst_no), 32'd0);
      chk("t6_words", words_o, 32'd0);
      check_writes("t6_abort", 0, 32'h0, 32'h0, 32'h0, 32'h0);
      send_frame(32'h00000100, 32'd2, 8'h00);
      chk("t6_loaded", 32'(loaded_o), 32'd1);
      check_writes("t6_fresh", 2, 32'h100, 32'hDEADBEEF, 32'h104, 32'h00000013);

      // Async reset mid-frame, then a fresh frame
      pulse_restart();
      begin
         logic [7:0] x = 8'd0;
         send_word(32'h00000300, x);
         send_word(32'd2, x);
         send_word(32'hCAFEF00D, x);
         send_byte(8'h77);
      end
      clear_log();
      rst_ni = 1'b0;
      #1;
      chk("t7_rst_core_rst_n", 32'(core_rst_no), 32'd0);
      chk("t7_rst_ready", 32'(byte_ready_o), 32'd0);
      chk("t7_rst_ram_en", 32'(ram_en_o), 32'd0);
      chk("t7_rst_words", words_o, 32'd0);
      chk("t7_rst_loaded", 32'(loaded_o), 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      repeat (3) @(negedge clk_i);
      check_writes("t7_abort", 0, 32'h0, 32'h0, 32'h0, 32'h0);
      send_frame(32'h00000100, 32'd2, 8'h00);
      chk("t7_loaded", 32'(loaded_o), 32'd1);
      chk("t7_core_rst_n", 32'(core_rst_no), 32'd1);
      check_writes("t7_fresh", 2, 32'h100, 32'hDEADBEEF, 32'h104, 32'h00000013);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
